i2s_transmitter: RTL

- Transmits 16-bit stereo samples as a Philips-format I2S stream (SCK, word clock, serial data) from the system clock.
- It is the transmit-direction counterpart of the audio receiver, intended to drive a codec DAC or to loop back into the receiver for self-test.
- Samples enter through a one-deep valid/ready holding buffer.
- Samples are serialised MSB-first with the standard one-SCK delay after each word-clock edge.

---
 rtl/i2s_transmitter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/i2s_transmitter.sv
// ============================================================================
// i2s_transmitter
//
// Purpose:
//   Serialises 16-bit (SAMPLE_W) stereo sample pairs into a Philips-format I2S
//   stream: serial clock, word clock and serial data, all registered and all
//   derived from the system clock. The stream can drive a codec DAC, or it can
//   be looped back into the matching audio receiver for self-test.
//
//   Sample pairs arrive through a one-deep valid/ready holding buffer. Once
//   per frame the buffer is moved into a 2*SAMPLE_W bit shifter, and the data
//   is shifted out MSB-first, left channel first. Each word-clock edge is
//   followed by the usual one-SCK delay before that word's MSB appears.
//
// Parameters:
//   CLK_DIV   clk cycles per SCK half-period. Must be 2 or more.
//   SAMPLE_W  bits per channel. A frame is 2*SAMPLE_W SCK periods long.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   audioL_in    left sample of the offered pair
//   audioR_in    right sample of the offered pair
//   in_valid     offered pair is valid
//   in_ready     holding buffer empty; pair taken when in_valid && in_ready
//   sck          I2S serial clock
//   wrdclk       word select (0 = left slot, 1 = right slot)
//   sdata        serial data; changes only on SCK falling edges
//   frame_start  one-clk pulse when a frame is loaded into the shifter
//   underrun     one-clk pulse when a frame loads while the buffer is empty
// ============================================================================
module i2s_transmitter #(
    parameter int CLK_DIV  = 16,
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] audioL_in,
    input  logic [SAMPLE_W-1:0] audioR_in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                sck,
    output logic                wrdclk,
    output logic                sdata,
    output logic                frame_start,
    output logic                underrun
);

    localparam int FRAME_W = 2 * SAMPLE_W;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W   = $clog2(FRAME_W);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] SLOT_LAST  = BIT_W'(FRAME_W - 1);
    localparam logic [BIT_W-1:0] SLOT_LOAD  = BIT_W'(1);
    localparam logic [BIT_W-1:0] SLOT_RIGHT = BIT_W'(SAMPLE_W);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DIV_W-1:0]    r_divCnt;
    logic                r_sck;
    logic                r_wrdclk;
    logic                r_sdata;
    logic [BIT_W-1:0]    r_bitCnt;
    logic [FRAME_W-1:0]  r_shifter;
    logic [SAMPLE_W-1:0] r_bufL;
    logic [SAMPLE_W-1:0] r_bufR;
    logic                r_bufFull;
    logic                r_frameStart;
    logic                r_underrun;

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    logic                w_divWrap;
    logic                w_fall;
    logic [BIT_W-1:0]    w_nextBit;
    logic                w_load;
    logic                w_accept;
    logic [FRAME_W-1:0]  w_loadWord;

    always_comb begin
        w_divWrap = (r_divCnt == DIV_LAST);
        // Every piece of serial state moves on the SCK falling edge. That
        // gives the receiver a full half-period of setup before each rise.
        w_fall    = w_divWrap && r_sck;
        w_nextBit = (r_bitCnt == SLOT_LAST) ? '0 : r_bitCnt + 1'b1;
        // A frame loads as slot 1 begins. This produces the one-SCK I2S delay
        // after the word clock falls at slot 0.
        w_load    = w_fall && (w_nextBit == SLOT_LOAD);
        // The accept path reads in_ready. Because in_ready is forced low while
        // rst is high, nothing is captured during reset.
        w_accept  = in_valid && in_ready;
        // An empty buffer sends silence rather than repeating stale data.
        w_loadWord = r_bufFull ? {r_bufL, r_bufR} : '0;
    end

    // ------------------------------------------------------------------
    // SCK divider
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_divCnt <= '0;
            r_sck    <= 1'b0;
        end else if (w_divWrap) begin
            r_divCnt <= '0;
            r_sck    <= ~r_sck;
        end else begin
            r_divCnt <= r_divCnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Slot counter and word clock
    // ------------------------------------------------------------------
    // The slot counter resets to the last slot, so the first fall after reset
    // opens slot 0 (the left word) and the first load comes one fall later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bitCnt <= SLOT_LAST;
            r_wrdclk <= 1'b1;
        end else if (w_fall) begin
            r_bitCnt <= w_nextBit;
            r_wrdclk <= (w_nextBit >= SLOT_RIGHT);
        end
    end

    // ------------------------------------------------------------------
    // Shifter and serial data
    // ------------------------------------------------------------------
    // On a load, the MSB goes straight to sdata and the shifter keeps the
    // rest of the frame, pre-shifted. At each later fall the shifter MSB moves
    // to sdata. The last bit (right LSB) therefore comes out in slot 0 of the
    // next frame, which is where I2S expects it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shifter <= '0;
            r_sdata   <= 1'b0;
        end else if (w_load) begin
            r_shifter <= {w_loadWord[FRAME_W-2:0], 1'b0};
            r_sdata   <= w_loadWord[FRAME_W-1];
        end else if (w_fall) begin
            r_shifter <= {r_shifter[FRAME_W-2:0], 1'b0};
            r_sdata   <= r_shifter[FRAME_W-1];
        end
    end

    // ------------------------------------------------------------------
    // Holding buffer
    // ------------------------------------------------------------------
    // Accept and load can only coincide when the buffer is already empty
    // (accept requires that). In that case the load has already taken
    // silence, and the new pair stays in the buffer for the following frame.
    // There is intentionally no bypass into the shifter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bufL    <= '0;
            r_bufR    <= '0;
            r_bufFull <= 1'b0;
        end else if (w_accept) begin
            r_bufL    <= audioL_in;
            r_bufR    <= audioR_in;
            r_bufFull <= 1'b1;
        end else if (w_load) begin
            r_bufFull <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Status pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frameStart <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_frameStart <= w_load;
            r_underrun   <= w_load && !r_bufFull;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready    = !r_bufFull && !rst;
    assign sck         = r_sck;
    assign wrdclk      = r_wrdclk;
    assign sdata       = r_sdata;
    assign frame_start = r_frameStart;
    assign underrun    = r_underrun;

endmodule
